// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding marker word and the
// padder state encoding (also used by the engine bench).
package sha256_pkg;

  localparam int          SHA256_BLK_WORDS = 16;
  localparam logic [31:0] SHA256_PAD_WORD  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAD  = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } padder_state_e;

  // Clamp a last-word byte count to 0..4 (codes 5..7 mean a full word).
  function automatic logic [2:0] sat_nbytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  // Last word with fewer than 4 bytes: keep the leading n bytes, put the
  // 0x80 marker in byte n and zero everything after it.
  function automatic logic [31:0] pad_last_word(input logic [31:0] dat,
                                                input logic [2:0]  n);
    logic [31:0] w;
    case (n)
      3'd0:    w = SHA256_PAD_WORD;
      3'd1:    w = {dat[31:24], 8'h80, 16'h0000};
      3'd2:    w = {dat[31:16], 8'h80, 8'h00};
      3'd3:    w = {dat[31:8], 8'h80};
      default: w = dat;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: passes the raw word stream straight into the
// engine FIFO, then appends the 0x80 marker, zero fill and the 64-bit bit
// length so that only whole 16-word blocks are ever written.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int BLKCNT_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic                in_vld_i,
  output logic                in_rdy_o,
  input  logic [31:0]         in_dat_i,
  input  logic                in_last_i,
  input  logic [2:0]          in_nbytes_i,
  input  logic                fifo_full_i,
  output logic                out_wr_en_o,
  output logic [31:0]         out_dat_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [BLKCNT_W-1:0] blocks_o,
  output logic [63:0]         msglen_o
);

  padder_state_e       state_q;
  logic [3:0]          wcnt_q;
  logic [60:0]         bytecnt_q;
  logic                len_ok_q;
  logic [BLKCNT_W-1:0] blocks_q;
  logic                busy_q;
  logic                done_q;

  logic                word_avail;
  logic [31:0]         word_dat;
  logic                marker_word;
  logic                wr;
  logic [2:0]          nbytes_sat;
  logic [3:0]          wcnt_d;
  logic [60:0]         bytecnt_d;

  assign nbytes_sat = sat_nbytes(in_nbytes_i);
  assign msglen_o   = {bytecnt_q, 3'b000};
  assign wcnt_d     = wcnt_q + 4'd1;
  assign bytecnt_d  = bytecnt_q + (in_last_i ? 61'(nbytes_sat) : 61'd4);

  // Select the word offered to the FIFO this cycle and whether it carries 0x80.
  always_comb begin
    word_avail  = 1'b0;
    word_dat    = 32'h0;
    marker_word = 1'b0;
    case (state_q)
      DATA: begin
        word_avail  = in_vld_i;
        word_dat    = in_last_i ? pad_last_word(in_dat_i, nbytes_sat) : in_dat_i;
        marker_word = in_last_i && (nbytes_sat != 3'd4);
      end
      PAD: begin
        word_avail  = 1'b1;
        word_dat    = SHA256_PAD_WORD;
        marker_word = 1'b1;
      end
      FILL: begin
        word_avail = 1'b1;
        if (len_ok_q && wcnt_q == 4'd14)      word_dat = msglen_o[63:32];
        else if (len_ok_q && wcnt_q == 4'd15) word_dat = msglen_o[31:0];
        else                                  word_dat = 32'h0;
      end
      default: ;
    endcase
  end

  assign wr          = word_avail & ~fifo_full_i;
  assign out_wr_en_o = wr;
  assign out_dat_o   = word_dat;
  assign in_rdy_o    = (state_q == DATA) & ~fifo_full_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign blocks_o    = blocks_q;

  // Padder FSM with slot/byte/block counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      bytecnt_q <= 61'd0;
      len_ok_q  <= 1'b0;
      blocks_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= DATA;
            wcnt_q    <= 4'd0;
            bytecnt_q <= 61'd0;
            len_ok_q  <= 1'b0;
            blocks_q  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          if (wr) begin
            wcnt_q <= wcnt_d;
            if (wcnt_q == 4'd15 && blocks_q != '1)
              blocks_q <= blocks_q + BLKCNT_W'(1);
            // Length fits once the marker sits in slots 0..13, or after the
            // block holding a late marker has been closed by a wrap.
            if ((marker_word && wcnt_q <= 4'd13) ||
                (wcnt_q == 4'd15 && (marker_word || state_q == FILL)))
              len_ok_q <= 1'b1;
            case (state_q)
              DATA: begin
                bytecnt_q <= bytecnt_d;
                if (in_last_i)
                  state_q <= (nbytes_sat == 3'd4) ? PAD : FILL;
              end
              PAD: state_q <= FILL;
              FILL: begin
                if (len_ok_q && wcnt_q == 4'd15) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
